// File: rtl/alu_wb_regfile.sv
// Register file, one-deep writeback slot with read bypass, and the {V,N,Z,C} flag register
// that sit between the picoMIPS decoder and the ALU.
module alu_wb_regfile #(
   parameter int n     = 8,
   parameter int NREGS = 32,
   parameter int AW    = 5
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [AW-1:0] ra_addr,
   input  logic [AW-1:0] rb_addr,
   output logic [n-1:0]  a_out,
   output logic [n-1:0]  b_out,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [n-1:0]  wr_data,
   input  logic          flag_en,
   input  logic [3:0]    flags_in,
   output logic [3:0]    flags_q,
   output logic          pend_valid,
   input  logic [AW-1:0] dbg_addr,
   output logic [n-1:0]  dbg_data
);

   logic [n-1:0]  r_mem [NREGS];
   logic          r_pend_valid;
   logic [AW-1:0] r_pend_addr;
   logic [n-1:0]  r_pend_data;
   logic [3:0]    r_flags;
   logic          w_wr_ok;

   function automatic logic f_in_range(input logic [AW-1:0] a);
      return 32'(a) < 32'(NREGS);
   endfunction

   // r0 and addresses beyond the array never occupy the slot
   assign w_wr_ok = wr_en && (wr_addr != '0) && f_in_range(wr_addr);

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) r_mem[i] <= '0;
         r_pend_valid <= 1'b0;
         r_pend_addr  <= '0;
         r_pend_data  <= '0;
         r_flags      <= 4'b0000;
      end else begin
         if (r_pend_valid) r_mem[r_pend_addr] <= r_pend_data;
         r_pend_valid <= w_wr_ok;
         if (w_wr_ok) begin
            r_pend_addr <= wr_addr;
            r_pend_data <= wr_data;
         end
         if (flag_en) r_flags <= flags_in;
      end
   end

   // Read ports see only registered state, so there is no path from wr_data to a_out/b_out
   always_comb begin
      a_out = '0;
      if ((ra_addr != '0) && f_in_range(ra_addr)) begin
         if (r_pend_valid && (r_pend_addr == ra_addr)) a_out = r_pend_data;
         else                                          a_out = r_mem[ra_addr];
      end
   end

   always_comb begin
      b_out = '0;
      if ((rb_addr != '0) && f_in_range(rb_addr)) begin
         if (r_pend_valid && (r_pend_addr == rb_addr)) b_out = r_pend_data;
         else                                          b_out = r_mem[rb_addr];
      end
   end

   always_comb begin
      dbg_data = '0;
      if ((dbg_addr != '0) && f_in_range(dbg_addr)) dbg_data = r_mem[dbg_addr];
   end

   assign flags_q    = r_flags;
   assign pend_valid = r_pend_valid;

endmodule

// File: tb/tb_alu_wb_regfile.sv
// Directed bench for alu_wb_regfile: stimulus queues expected outputs per cycle,
// a monitor compares them at the falling edge of that cycle.
module tb_alu_wb_regfile;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [4:0] ra_addr = '0, rb_addr = '0, wr_addr = '0, dbg_addr = '0;
   logic [7:0] a_out, b_out, wr_data = '0, dbg_data;
   logic       wr_en = 1'b0, flag_en = 1'b0, pend_valid;
   logic [3:0] flags_in = '0, flags_q;

   alu_wb_regfile #(.n(8), .NREGS(32), .AW(5)) dut (
      .clk(clk), .reset(reset),
      .ra_addr(ra_addr), .rb_addr(rb_addr), .a_out(a_out), .b_out(b_out),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .flag_en(flag_en), .flags_in(flags_in), .flags_q(flags_q),
      .pend_valid(pend_valid), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      int         kind;   // 0 a_out, 1 b_out, 2 dbg_data, 3 flags_q, 4 pend_valid
      logic [7:0] exp;
      string      name;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   n_pass = 0;
   int   n_total = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic expect_out(input int kind, input logic [7:0] val, input string name);
      exp_t e;
      e.cyc = cyc; e.kind = kind; e.exp = val; e.name = name;
      sb.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr_en = 1'b0; flag_en = 1'b0;
   endtask

   task automatic wr(input logic [4:0] a, input logic [7:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
   endtask

   // Monitor
   initial begin
      forever begin
         @(negedge clk);
         while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            logic [7:0] act;
            e = sb.pop_front();
            case (e.kind)
               0:       act = a_out;
               1:       act = b_out;
               2:       act = dbg_data;
               3:       act = {4'h0, flags_q};
               default: act = {7'h0, pend_valid};
            endcase
            n_total++;
            if (e.cyc == cyc && act === e.exp) n_pass++;
            else $display("FAIL %s: got %h expected %h (cycle %0d, queued %0d)",
                          e.name, act, e.exp, cyc, e.cyc);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      step(); step();
      reset = 1'b0;

      // Post-reset contents on every address and both ports
      for (int i = 0; i < 32; i++) begin
         ra_addr = 5'(i); rb_addr = 5'(31 - i); dbg_addr = 5'(i);
         expect_out(0, 8'h00, "reset_a");
         expect_out(1, 8'h00, "reset_b");
         expect_out(2, 8'h00, "reset_dbg");
         if (i == 0) begin
            expect_out(3, 8'h00, "reset_flags");
            expect_out(4, 8'h00, "reset_pend");
         end
         step();
      end

      // r3 = A5: bypass before commit, array after
      wr(5'd3, 8'hA5);
      step();
      idle(); ra_addr = 5'd3; rb_addr = 5'd3; dbg_addr = 5'd3;
      expect_out(0, 8'hA5, "byp_a_r3");
      expect_out(1, 8'hA5, "byp_b_r3");
      expect_out(2, 8'h00, "dbg_r3_uncommitted");
      expect_out(4, 8'h01, "pend_r3");
      step();
      expect_out(2, 8'hA5, "dbg_r3_committed");
      expect_out(0, 8'hA5, "arr_a_r3");
      expect_out(4, 8'h00, "pend_clear_r3");
      step();

      // Same-address back-to-back: r7 = 11 then 22
      wr(5'd7, 8'h11);
      step();
      wr(5'd7, 8'h22); ra_addr = 5'd7; dbg_addr = 5'd7;
      expect_out(0, 8'h11, "r7_after_e1");
      expect_out(2, 8'h00, "dbg_r7_after_e1");
      step();
      idle();
      expect_out(0, 8'h22, "r7_after_e2");
      expect_out(2, 8'h11, "dbg_r7_after_e2");
      expect_out(4, 8'h01, "pend_r7_e2");
      step();
      expect_out(0, 8'h22, "r7_after_e3");
      expect_out(2, 8'h22, "dbg_r7_after_e3");
      step();

      // r4 = 3C pending, then r0 write is dropped while r4 still commits
      wr(5'd4, 8'h3C);
      step();
      wr(5'd0, 8'hFF);
      expect_out(4, 8'h01, "pend_r4");
      step();
      idle(); ra_addr = 5'd0; rb_addr = 5'd0; dbg_addr = 5'd4;
      expect_out(0, 8'h00, "r0_a");
      expect_out(1, 8'h00, "r0_b");
      expect_out(4, 8'h00, "r0_no_pend");
      expect_out(2, 8'h3C, "r4_committed");
      step();
      dbg_addr = 5'd0;
      expect_out(2, 8'h00, "dbg_r0");
      step();

      // Different-address back-to-back: port A from array, port B from bypass
      wr(5'd1, 8'h01);
      step();
      wr(5'd2, 8'h02);
      step();
      idle(); ra_addr = 5'd1; rb_addr = 5'd2;
      expect_out(0, 8'h01, "b2b_a_array");
      expect_out(1, 8'h02, "b2b_b_bypass");
      step();

      // No same-cycle feedthrough of wr_data
      wr(5'd9, 8'h99); ra_addr = 5'd9;
      expect_out(0, 8'h00, "no_feedthrough");
      step();
      idle();
      expect_out(0, 8'h99, "r9_next_cycle");
      step();

      // Flags load then hold
      flag_en = 1'b1; flags_in = 4'b1001;
      expect_out(3, 8'h00, "flags_before_load");
      step();
      flag_en = 1'b0; flags_in = 4'b0110;
      expect_out(3, 8'h09, "flags_loaded");
      step();
      expect_out(3, 8'h09, "flags_held");
      step();

      // Reset discards a pending write and clears everything
      wr(5'd5, 8'h5A);
      step();
      idle(); reset = 1'b1;
      expect_out(4, 8'h01, "pend_r5");
      step();
      reset = 1'b0; ra_addr = 5'd5; rb_addr = 5'd5; dbg_addr = 5'd5;
      expect_out(0, 8'h00, "r5_a_after_reset");
      expect_out(1, 8'h00, "r5_b_after_reset");
      expect_out(2, 8'h00, "dbg_r5_after_reset");
      expect_out(4, 8'h00, "pend_after_reset");
      expect_out(3, 8'h00, "flags_after_reset");
      step();
      dbg_addr = 5'd3; ra_addr = 5'd5;
      expect_out(2, 8'h00, "dbg_r3_after_reset");
      expect_out(0, 8'h00, "r5_not_committed");
      step();

      // Reset overrides wr_en and flag_en in the same cycle
      reset = 1'b1; wr(5'd6, 8'h77); flag_en = 1'b1; flags_in = 4'b1111;
      step();
      reset = 1'b0; idle(); ra_addr = 5'd6; dbg_addr = 5'd6;
      expect_out(0, 8'h00, "reset_over_wr_a");
      expect_out(4, 8'h00, "reset_over_wr_pend");
      expect_out(3, 8'h00, "reset_over_flag");
      step();
      expect_out(2, 8'h00, "reset_over_wr_dbg");
      step();
      step();

      n_total++;
      if (sb.size() == 0) n_pass++;
      else $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/alu_wb_regfile.md
Name: alu_wb_regfile

Overview:
- Register file and writeback stage directly upstream and downstream of the picoMIPS ALU.
- Supplies the ALU operands a and b from two combinational read ports.
- Accepts the ALU result through a one-deep registered writeback slot, with bypass so a just-written value is readable the next cycle.
- Holds the architectural V,N,Z,C flag register that the branch logic consumes.

Parameters:
- n, 8, data width; must match the ALU width.
- NREGS, 32, number of registers; register 0 is hardwired to zero.
- AW, 5, address width; clog2(NREGS).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- ra_addr  input  AW  read port A address.
- rb_addr  input  AW  read port B address.
- a_out  output  n  port A data, driven to ALU operand a.
- b_out  output  n  port B data, driven to ALU operand b.
- wr_en  input  1  writeback request this cycle.
- wr_addr  input  AW  writeback destination register.
- wr_data  input  n  writeback data, taken from the ALU result.
- flag_en  input  1  load the flag register this cycle.
- flags_in  input  4  ALU flags, ordered {V,N,Z,C}.
- flags_q  output  4  registered flags, ordered {V,N,Z,C}.
- pend_valid  output  1  writeback slot occupied; status and debug only.
- dbg_addr  input  AW  debug read address.
- dbg_data  output  n  committed array contents at dbg_addr; no bypass.

Behaviour:
- Reset, when reset=1 at a clock edge:
  - all array entries set to 0;
  - pending slot cleared: pend_valid=0, pending address 0, pending data 0;
  - flags_q set to 4'b0000.
  - Reset overrides wr_en and flag_en in the same cycle.
  - A reset asserted while a write is pending discards that write; it is never committed.
- Writeback pipeline, two stages:
  - Edge t, with wr_en=1 and wr_addr!=0: pending slot loads wr_addr/wr_data and pend_valid becomes 1.
  - Edge t+1: if pend_valid=1, the pending data is committed into the array at the pending address.
  - At the same edge t+1, the slot reloads from the current wr_en/wr_addr/wr_data. pend_valid stays 1 if wr_en=1, else it clears.
  - Back-to-back writes need no stall; throughput is one write per cycle.
  - wr_en=1 with wr_addr=0 is ignored: pend_valid is not set, and any in-flight pending write still commits.
- Read ports (combinational, same-cycle address to data):
  - Address 0 always returns 0.
  - Else, if pend_valid=1 and the pending address equals the read address, return the pending data (bypass).
  - Else return the array entry.
  - Bypass covers exactly one pending write. The array is always up to date for anything older.
  - Same-address consecutive writes W1 at edge t and W2 at edge t+1: after edge t+1 reads return W2 via bypass. After edge t+2 the array holds W2; W1 was committed at t+1 and overwritten at t+2.
  - Writeback data is never fed through combinationally to a_out/b_out in the same cycle it is presented on wr_data. No comb loop through the ALU is permitted.
- Flag register:
  - flag_en=1 at an edge: flags_q <= flags_in.
  - flag_en=0: hold.
  - Flags are independent of wr_en; the controller asserts flag_en only for ADD/SUB/MUL.
  - Zero latency is not provided: flags_q reflects flags_in one cycle later.
- dbg_data: combinational read of the committed array only; address 0 returns 0.
- Arithmetic and width: no arithmetic in this block. Data is passed unmodified at n bits.
- Out-of-range addresses (addr >= NREGS, when NREGS < 2^AW): reads return 0 and writes are ignored.

Test Plan:
- Reset then read all 32 addresses on both ports -> every a_out/b_out/dbg_data = 8'h00, flags_q=4'h0, pend_valid=0.
- Write 8'hA5 to r3 at edge 1 and set ra_addr=3 in the following cycle -> a_out=8'hA5 via bypass while dbg_data(3)=8'h00. After edge 2, dbg_data(3)=8'hA5.
- Write r7=8'h11 at edge 1, r7=8'h22 at edge 2, then idle -> ra_addr=7 gives 8'h11 after edge 1, 8'h22 after edge 2 and later. dbg_data(7)=8'h11 after edge 2, 8'h22 after edge 3.
- Write r0=8'hFF, then read r0 on both ports -> 8'h00. pend_valid stays 0. A preceding pending write to r4=8'h3C still commits.
- flag_en=1 with flags_in=4'b1001, then flag_en=0 with flags_in=4'b0110 -> flags_q=4'b1001 after the first edge and held after the second.
- Write r5=8'h5A, assert reset on the next edge -> dbg_data(5)=8'h00, pend_valid=0, and reads of r5 return 8'h00.
